// File: rtl/grant_deserializer_pkg.sv
// Shared definitions for the grant deserializer: FSM state encoding,
// beat-count legality and counter-width helpers.
package grant_deserializer_pkg;

    // Width of the incoming addr_beat field
    localparam int ADDR_BEAT_W = 3;

    // Binary-encoded deserializer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HOLD = 2'd2
    } gd_state_e;

    // True when the number of beats per block is a supported value
    function automatic bit beats_legal(input int beats);
        return (beats == 2) || (beats == 4) || (beats == 8);
    endfunction

    // Bits needed to index DATA_BEATS slots (ceil(log2)), minimum 1
    function automatic int cnt_width(input int beats);
        int w;
        w = 0;
        while ((1 << w) < beats) begin
            w = w + 1;
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/grant_beat_buffer.sv
// Write-indexed register array holding one data block of DATA_BEATS beats.
// Beat k is presented flat at rd_data[k*BEAT_W +: BEAT_W].
module grant_beat_buffer
    import grant_deserializer_pkg::*;
#(
    parameter int DATA_BEATS = 4,
    parameter int BEAT_W     = 64,
    parameter int CNT_W      = cnt_width(DATA_BEATS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clr,
    input  logic                         wr_en,
    input  logic [CNT_W-1:0]             wr_idx,
    input  logic [BEAT_W-1:0]            wr_data,
    output logic [DATA_BEATS*BEAT_W-1:0] rd_data
);

    logic [BEAT_W-1:0] slot_r [DATA_BEATS];

    // Slot storage: clear the whole block or write one slot per accepted beat
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DATA_BEATS; i++) begin
                slot_r[i] <= {BEAT_W{1'b0}};
            end
        end else if (clr) begin
            for (int i = 0; i < DATA_BEATS; i++) begin
                slot_r[i] <= {BEAT_W{1'b0}};
            end
        end else if (wr_en) begin
            slot_r[wr_idx] <= wr_data;
        end
    end

    for (genvar g = 0; g < DATA_BEATS; g++) begin : g_flat
        assign rd_data[g*BEAT_W +: BEAT_W] = slot_r[g];
    end

endmodule

// File: rtl/grant_deserializer.sv
// Collects grant beats into one DATA_BEATS-wide block with the header taken
// from the first beat, then holds the block until the consumer takes it.
// io_done / io_seq_err are same-cycle pulses on the accepting beat; every
// other output comes straight from a register.
module grant_deserializer
    import grant_deserializer_pkg::*;
#(
    parameter int DATA_BEATS = 4,
    parameter int BEAT_W     = 64
) (
    input  logic                               clk,
    input  logic                               reset,
    output logic                               io_in_ready,
    input  logic                               io_in_valid,
    input  logic [2:0]                         io_in_bits_addr_beat,
    input  logic                               io_in_bits_client_xact_id,
    input  logic [1:0]                         io_in_bits_manager_xact_id,
    input  logic                               io_in_bits_is_builtin_type,
    input  logic [3:0]                         io_in_bits_g_type,
    input  logic [BEAT_W-1:0]                  io_in_bits_data,
    input  logic                               io_in_has_data,
    input  logic                               io_out_ready,
    output logic                               io_out_valid,
    output logic                               io_out_bits_client_xact_id,
    output logic [1:0]                         io_out_bits_manager_xact_id,
    output logic                               io_out_bits_is_builtin_type,
    output logic [3:0]                         io_out_bits_g_type,
    output logic [DATA_BEATS*BEAT_W-1:0]       io_out_bits_data,
    output logic [cnt_width(DATA_BEATS)-1:0]   io_cnt,
    output logic                               io_done,
    output logic                               io_seq_err
);

    localparam int CNT_W = cnt_width(DATA_BEATS);

    if (!beats_legal(DATA_BEATS)) begin : g_bad_beats
        $error("grant_deserializer: DATA_BEATS must be 2, 4 or 8");
    end

    gd_state_e              state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   in_ready_r;
    logic                   out_valid_r;
    logic                   cid_r;
    logic [1:0]             mid_r;
    logic                   builtin_r;
    logic [3:0]             gtype_r;

    logic                   accept_s;
    logic                   last_beat_s;
    logic                   addr_mismatch_s;
    logic                   id_mismatch_s;
    logic [ADDR_BEAT_W-1:0] cnt_ext_s;
    logic                   buf_clr_s;
    logic                   buf_wr_s;
    logic [CNT_W-1:0]       buf_idx_s;
    logic                   done_s;
    logic                   seq_err_s;

    // Beat acceptance, sequence checks and buffer write controls
    always_comb begin
        accept_s        = io_in_valid && in_ready_r && !reset;
        cnt_ext_s       = ADDR_BEAT_W'(cnt_r);
        addr_mismatch_s = (io_in_bits_addr_beat != cnt_ext_s);
        id_mismatch_s   = (io_in_bits_client_xact_id != cid_r) ||
                          (io_in_bits_manager_xact_id != mid_r);
        last_beat_s     = (cnt_r == CNT_W'(DATA_BEATS - 1));
        buf_clr_s       = 1'b0;
        buf_wr_s        = 1'b0;
        buf_idx_s       = cnt_r;
        done_s          = 1'b0;
        seq_err_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    seq_err_s = addr_mismatch_s;
                    if (io_in_has_data) begin
                        buf_wr_s = 1'b1;
                        done_s   = 1'b0;
                    end else begin
                        buf_clr_s = 1'b1;
                        done_s    = 1'b1;
                    end
                end else begin
                    seq_err_s = 1'b0;
                end
            end
            ST_FILL: begin
                if (accept_s) begin
                    buf_wr_s  = 1'b1;
                    done_s    = last_beat_s;
                    seq_err_s = addr_mismatch_s || id_mismatch_s;
                end else begin
                    buf_wr_s = 1'b0;
                end
            end
            ST_HOLD: begin
                buf_wr_s = 1'b0;
            end
            default: begin
                buf_wr_s = 1'b0;
            end
        endcase
    end

    // Control FSM with header capture; ready/valid change only on state moves
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            cid_r       <= 1'b0;
            mid_r       <= 2'b00;
            builtin_r   <= 1'b0;
            gtype_r     <= 4'h0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cid_r     <= io_in_bits_client_xact_id;
                        mid_r     <= io_in_bits_manager_xact_id;
                        builtin_r <= io_in_bits_is_builtin_type;
                        gtype_r   <= io_in_bits_g_type;
                        if (io_in_has_data) begin
                            cnt_r   <= CNT_W'(1);
                            state_r <= ST_FILL;
                        end else begin
                            cnt_r       <= {CNT_W{1'b0}};
                            state_r     <= ST_HOLD;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    if (accept_s) begin
                        if (last_beat_s) begin
                            cnt_r       <= {CNT_W{1'b0}};
                            state_r     <= ST_HOLD;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (io_out_ready) begin
                        state_r     <= ST_IDLE;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cnt_r       <= {CNT_W{1'b0}};
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    grant_beat_buffer #(
        .DATA_BEATS (DATA_BEATS),
        .BEAT_W     (BEAT_W),
        .CNT_W      (CNT_W)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .clr     (buf_clr_s),
        .wr_en   (buf_wr_s),
        .wr_idx  (buf_idx_s),
        .wr_data (io_in_bits_data),
        .rd_data (io_out_bits_data)
    );

    assign io_in_ready                 = in_ready_r;
    assign io_out_valid                = out_valid_r;
    assign io_out_bits_client_xact_id  = cid_r;
    assign io_out_bits_manager_xact_id = mid_r;
    assign io_out_bits_is_builtin_type = builtin_r;
    assign io_out_bits_g_type          = gtype_r;
    assign io_cnt                      = cnt_r;
    assign io_done                     = done_s;
    assign io_seq_err                  = seq_err_s;

endmodule

// File: tb/tb_grant_deserializer.sv
// Scoreboard bench for grant_deserializer (DATA_BEATS=4, BEAT_W=64).
module tb_grant_deserializer;

    logic         clk;
    logic         reset;
    logic         io_in_ready;
    logic         io_in_valid;
    logic [2:0]   io_in_bits_addr_beat;
    logic         io_in_bits_client_xact_id;
    logic [1:0]   io_in_bits_manager_xact_id;
    logic         io_in_bits_is_builtin_type;
    logic [3:0]   io_in_bits_g_type;
    logic [63:0]  io_in_bits_data;
    logic         io_in_has_data;
    logic         io_out_ready;
    logic         io_out_valid;
    logic         io_out_bits_client_xact_id;
    logic [1:0]   io_out_bits_manager_xact_id;
    logic         io_out_bits_is_builtin_type;
    logic [3:0]   io_out_bits_g_type;
    logic [255:0] io_out_bits_data;
    logic [1:0]   io_cnt;
    logic         io_done;
    logic         io_seq_err;

    typedef struct {
        logic [255:0] data;
        logic         cid;
        logic [1:0]   mid;
        logic         blt;
        logic [3:0]   gt;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic done_d   = 1'b0;

    grant_deserializer #(.DATA_BEATS(4), .BEAT_W(64)) dut (
        .clk                         (clk),
        .reset                       (reset),
        .io_in_ready                 (io_in_ready),
        .io_in_valid                 (io_in_valid),
        .io_in_bits_addr_beat        (io_in_bits_addr_beat),
        .io_in_bits_client_xact_id   (io_in_bits_client_xact_id),
        .io_in_bits_manager_xact_id  (io_in_bits_manager_xact_id),
        .io_in_bits_is_builtin_type  (io_in_bits_is_builtin_type),
        .io_in_bits_g_type           (io_in_bits_g_type),
        .io_in_bits_data             (io_in_bits_data),
        .io_in_has_data              (io_in_has_data),
        .io_out_ready                (io_out_ready),
        .io_out_valid                (io_out_valid),
        .io_out_bits_client_xact_id  (io_out_bits_client_xact_id),
        .io_out_bits_manager_xact_id (io_out_bits_manager_xact_id),
        .io_out_bits_is_builtin_type (io_out_bits_is_builtin_type),
        .io_out_bits_g_type          (io_out_bits_g_type),
        .io_out_bits_data            (io_out_bits_data),
        .io_cnt                      (io_cnt),
        .io_done                     (io_done),
        .io_seq_err                  (io_seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to measure block period
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] pack4(input logic [63:0] b0, input logic [63:0] b1,
                                           input logic [63:0] b2, input logic [63:0] b3);
        return {b3, b2, b1, b0};
    endfunction

    task automatic push_exp(input logic [255:0] d, input logic cid, input logic [1:0] mid,
                            input logic blt, input logic [3:0] gt);
        exp_t e;
        e.data = d; e.cid = cid; e.mid = mid; e.blt = blt; e.gt = gt;
        sb_q.push_back(e);
    endtask

    // Monitor: pops the scoreboard on each output handshake, checks latency
    always @(negedge clk) begin
        exp_t e;
        if (done_d && !reset) chk("valid_after_done", int'(io_out_valid), 1);
        done_d <= io_done;
        if (io_out_valid && io_out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_block actual=%0h expected=none", io_out_bits_data);
            end else begin
                e = sb_q.pop_front();
                chkw("out_data", io_out_bits_data, e.data);
                chk("out_cid", int'(io_out_bits_client_xact_id), int'(e.cid));
                chk("out_mid", int'(io_out_bits_manager_xact_id), int'(e.mid));
                chk("out_builtin", int'(io_out_bits_is_builtin_type), int'(e.blt));
                chk("out_gtype", int'(io_out_bits_g_type), int'(e.gt));
            end
        end
    end

    // Present one beat, wait (bounded) for acceptance, check the pulses
    task automatic beat(input logic [2:0] ab, input logic [63:0] d, input logic cid,
                        input logic [1:0] mid, input logic blt, input logic [3:0] gt,
                        input logic hd, input logic exp_done, input logic exp_seq,
                        output int acc_cyc);
        int n;
        io_in_valid                = 1'b1;
        io_in_bits_addr_beat       = ab;
        io_in_bits_data            = d;
        io_in_bits_client_xact_id  = cid;
        io_in_bits_manager_xact_id = mid;
        io_in_bits_is_builtin_type = blt;
        io_in_bits_g_type          = gt;
        io_in_has_data             = hd;
        n = 0;
        @(negedge clk);
        while (!io_in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!io_in_ready) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout actual=0 expected=1");
        end
        chk("done_pulse", int'(io_done), int'(exp_done));
        chk("seq_err_pulse", int'(io_seq_err), int'(exp_seq));
        acc_cyc = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        io_in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        int t0 [3];
        int n;
        logic [2:0]  seq_ab [4];
        logic        seq_er [4];
        logic [255:0] stall_exp;
        logic [1:0]  bb;

        reset = 1'b1;
        io_in_valid = 1'b0;
        io_in_bits_addr_beat = 3'd0;
        io_in_bits_data = 64'h0;
        io_in_bits_client_xact_id = 1'b0;
        io_in_bits_manager_xact_id = 2'd0;
        io_in_bits_is_builtin_type = 1'b0;
        io_in_bits_g_type = 4'h0;
        io_in_has_data = 1'b0;
        io_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", int'(io_out_valid), 0);
        chk("rst_in_ready", int'(io_in_ready), 1);
        chk("rst_cnt", int'(io_cnt), 0);
        chk("rst_done", int'(io_done), 0);
        chk("rst_seq_err", int'(io_seq_err), 0);
        chkw("rst_data", io_out_bits_data, 256'h0);
        @(posedge clk); #1;

        // Four in-order beats
        push_exp(pack4(64'hA0, 64'hA1, 64'hA2, 64'hA3), 1'b1, 2'd2, 1'b0, 4'h5);
        for (int k = 0; k < 4; k++)
            beat(3'(k), 64'hA0 + 64'(k), 1'b1, 2'd2, 1'b0, 4'h5, 1'b1, k == 3, 1'b0, t);
        idle(3);

        // Single beat without data: block is all zeros, cnt stays 0
        push_exp(256'h0, 1'b0, 2'd3, 1'b1, 4'h0);
        beat(3'd0, 64'hDEAD, 1'b0, 2'd3, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, t);
        io_in_valid = 1'b0;
        @(negedge clk);
        chk("cnt_nodata", int'(io_cnt), 0);
        idle(3);

        // Back-pressure: block held stable while io_out_ready is low
        stall_exp = pack4(64'hC0, 64'hC1, 64'hC2, 64'hC3);
        push_exp(stall_exp, 1'b0, 2'd1, 1'b0, 4'h1);
        for (int k = 0; k < 3; k++)
            beat(3'(k), 64'hC0 + 64'(k), 1'b0, 2'd1, 1'b0, 4'h1, 1'b1, 1'b0, 1'b0, t);
        io_out_ready = 1'b0;
        beat(3'd3, 64'hC3, 1'b0, 2'd1, 1'b0, 4'h1, 1'b1, 1'b1, 1'b0, t);
        io_in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", int'(io_in_ready), 0);
            chk("stall_out_valid", int'(io_out_valid), 1);
            chkw("stall_data", io_out_bits_data, stall_exp);
        end
        @(posedge clk); #1;
        io_out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("release_in_ready", int'(io_in_ready), 1);
        chk("release_out_valid", int'(io_out_valid), 0);
        idle(2);

        // Out-of-sequence addr_beat 0,2,1,3: errors on beats 2 and 3, arrival order kept
        seq_ab = '{3'd0, 3'd2, 3'd1, 3'd3};
        seq_er = '{1'b0, 1'b1, 1'b1, 1'b0};
        push_exp(pack4(64'hB0, 64'hB1, 64'hB2, 64'hB3), 1'b1, 2'd0, 1'b0, 4'h2);
        for (int k = 0; k < 4; k++)
            beat(seq_ab[k], 64'hB0 + 64'(k), 1'b1, 2'd0, 1'b0, 4'h2, 1'b1, k == 3, seq_er[k], t);
        idle(3);

        // Id mismatch inside a block flags an error; captured header unchanged
        push_exp(pack4(64'hD0, 64'hD1, 64'hD2, 64'hD3), 1'b1, 2'd1, 1'b0, 4'h6);
        beat(3'd0, 64'hD0, 1'b1, 2'd1, 1'b0, 4'h6, 1'b1, 1'b0, 1'b0, t);
        beat(3'd1, 64'hD1, 1'b1, 2'd1, 1'b0, 4'h6, 1'b1, 1'b0, 1'b0, t);
        beat(3'd2, 64'hD2, 1'b0, 2'd1, 1'b0, 4'h6, 1'b1, 1'b0, 1'b1, t);
        beat(3'd3, 64'hD3, 1'b1, 2'd2, 1'b0, 4'h6, 1'b1, 1'b1, 1'b1, t);
        idle(3);

        // Reset after two beats discards the partial block
        beat(3'd0, 64'hF0, 1'b1, 2'd3, 1'b0, 4'h7, 1'b1, 1'b0, 1'b0, t);
        beat(3'd1, 64'hF1, 1'b1, 2'd3, 1'b0, 4'h7, 1'b1, 1'b0, 1'b0, t);
        io_in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", int'(io_out_valid), 0);
        chk("midrst_cnt", int'(io_cnt), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("postrst_in_ready", int'(io_in_ready), 1);
        chk("postrst_cnt", int'(io_cnt), 0);
        @(posedge clk); #1;
        push_exp(pack4(64'hE0, 64'hE1, 64'hE2, 64'hE3), 1'b0, 2'd2, 1'b1, 4'h3);
        for (int k = 0; k < 4; k++)
            beat(3'(k), 64'hE0 + 64'(k), 1'b0, 2'd2, 1'b1, 4'h3, 1'b1, k == 3, 1'b0, t);
        idle(3);

        // Back-to-back blocks, valid held high; block 1 drops has_data mid-block
        for (int b = 0; b < 3; b++) begin
            bb = 2'(b);
            push_exp(pack4(64'h5000 + 64'(b*16), 64'h5001 + 64'(b*16),
                           64'h5002 + 64'(b*16), 64'h5003 + 64'(b*16)),
                     bb[0], bb, 1'b0, 4'h4);
        end
        for (int b = 0; b < 3; b++) begin
            bb = 2'(b);
            for (int k = 0; k < 4; k++) begin
                beat(3'(k), 64'h5000 + 64'(b*16 + k), bb[0], bb, 1'b0, 4'h4,
                     (b == 1 && k > 0) ? 1'b0 : 1'b1, k == 3, 1'b0, t);
                if (k == 0) t0[b] = t;
            end
        end
        io_in_valid = 1'b0;
        chk("period_0_1", t0[1] - t0[0], 5);
        chk("period_1_2", t0[2] - t0[1], 5);

        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", sb_q.size(), 0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
